// File: rtl/cfg_dma_initiator.sv
// cfg_dma_initiator
// -----------------
// Host-side initiator for the simplified MMIO/config bus. It takes one DMA
// descriptor, programs the DMA engine with six MMIO writes (src lo/hi,
// dst lo/hi, len, start), then polls the DMA status register until its done
// bit is set. The descriptor ends with a one-cycle done pulse. done_err flags
// either a missing response or too many unsuccessful polls.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   desc_valid/ready  descriptor handshake (desc_src, desc_dst, desc_len)
//   busy              descriptor in flight (acceptance+1 .. done, inclusive)
//   done, done_err    completion pulse; done_err=1 means a timeout occurred
//   cfg_req_*         MMIO request (valid, addr, wdata), all registered
//   cfg_resp_*        MMIO response (valid, rdata); rdata[0] = DMA done
//   dbg_state         current FSM state, for debug and checkers
//
// Handshakes
//   Descriptor: a descriptor is taken on any rising edge where desc_valid and
//   desc_ready are both high. desc_ready is high only in IDLE.
//   Request: cfg_req_addr and cfg_req_wdata stay stable while cfg_req_valid is
//   high. The request completes on the first edge where cfg_req_valid and
//   cfg_resp_valid are both high; a response may arrive in the same cycle as
//   the request. Only one request is outstanding at a time. cfg_resp_valid is
//   ignored while cfg_req_valid is low.

module cfg_dma_initiator #(
    parameter int RESP_TIMEOUT = 16,
    parameter int POLL_GAP     = 4,
    parameter int POLL_LIMIT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [63:0] desc_src,
    input  logic [63:0] desc_dst,
    input  logic [31:0] desc_len,
    output logic        busy,
    output logic        done,
    output logic        done_err,
    output logic        cfg_req_valid,
    output logic [31:0] cfg_req_addr,
    output logic [31:0] cfg_req_wdata,
    input  logic        cfg_resp_valid,
    input  logic [31:0] cfg_resp_rdata,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_GAP    = 3'd2,
        S_POLL   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [31:0] ADDR_SRC_LO = 32'h0000_0010;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_002C;
    localparam logic [15:0] RESP_LAST   = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_MAX    = 16'(POLL_LIMIT);

    state_t      state_q, state_d;
    logic [63:0] src_q, src_d;
    logic [63:0] dst_q, dst_d;
    logic [31:0] len_q, len_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] resp_cnt_q, resp_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        err_q, err_d;

    logic        resp_hit;
    logic [2:0]  idx_next;
    logic [15:0] poll_inc;
    logic        unused_rdata;

    assign resp_hit     = req_valid_q & cfg_resp_valid;
    assign idx_next     = idx_q + 3'd1;
    assign poll_inc     = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
    assign unused_rdata = ^cfg_resp_rdata[31:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            idx_q       <= '0;
            resp_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            poll_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            idx_q       <= idx_d;
            resp_cnt_q  <= resp_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        idx_d       = idx_q;
        resp_cnt_d  = resp_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (desc_valid) begin
                    src_d      = desc_src;
                    dst_d      = desc_dst;
                    len_d      = desc_len;
                    poll_cnt_d = '0;
                    resp_cnt_d = '0;
                    err_d      = 1'b0;
                    if (desc_len == 32'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        // The first write uses the live input because the
                        // captured copy is only available next cycle.
                        state_d     = S_WRITE;
                        req_valid_d = 1'b1;
                        req_addr_d  = ADDR_SRC_LO;
                        req_wdata_d = desc_src[31:0];
                        idx_d       = '0;
                    end
                end
            end

            S_WRITE, S_POLL: begin
                if (resp_hit) begin
                    resp_cnt_d = '0;
                    if (state_q == S_WRITE && idx_q != 3'd5) begin
                        // Next write issues back-to-back, no bubble.
                        idx_d       = idx_next;
                        req_addr_d  = ADDR_SRC_LO + {27'd0, idx_next, 2'b00};
                        case (idx_next)
                            3'd1:    req_wdata_d = src_q[63:32];
                            3'd2:    req_wdata_d = dst_q[31:0];
                            3'd3:    req_wdata_d = dst_q[63:32];
                            3'd4:    req_wdata_d = len_q;
                            default: req_wdata_d = 32'h0000_0001;
                        endcase
                    end else if (state_q == S_POLL && cfg_resp_rdata[0]) begin
                        state_d     = S_FINISH;
                        req_valid_d = 1'b0;
                        err_d       = 1'b0;
                    end else if (state_q == S_POLL && poll_inc >= POLL_MAX) begin
                        poll_cnt_d  = poll_inc;
                        state_d     = S_FINISH;
                        req_valid_d = 1'b0;
                        err_d       = 1'b1;
                    end else begin
                        // Either the start write just landed or a poll missed:
                        // both lead into the inter-poll gap (skipped if zero).
                        if (state_q == S_POLL) begin
                            poll_cnt_d = poll_inc;
                        end
                        if (POLL_GAP == 0) begin
                            state_d     = S_POLL;
                            req_valid_d = 1'b1;
                            req_addr_d  = ADDR_STATUS;
                            req_wdata_d = '0;
                        end else begin
                            state_d     = S_GAP;
                            req_valid_d = 1'b0;
                            gap_cnt_d   = '0;
                        end
                    end
                end else if (resp_cnt_q >= RESP_LAST) begin
                    state_d     = S_FINISH;
                    req_valid_d = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    resp_cnt_d = resp_cnt_q + 16'd1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    state_d     = S_POLL;
                    req_valid_d = 1'b1;
                    req_addr_d  = ADDR_STATUS;
                    req_wdata_d = '0;
                    resp_cnt_d  = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    assign desc_ready    = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FINISH);
    assign done_err      = (state_q == S_FINISH) & err_q;
    assign cfg_req_valid = req_valid_q;
    assign cfg_req_addr  = req_addr_q;
    assign cfg_req_wdata = req_wdata_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/cfg_dma_initiator.md
Name: cfg_dma_initiator

Overview:
- Initiator for the simplified MMIO/config bus (cfg_req_*/cfg_resp_*). It accepts one DMA descriptor and programs the DMA registers through MMIO writes: src lo/hi, dst lo/hi, len, start.
- It then polls the DMA status register until the done bit is set, or until a timeout.
- It sits on the host/command-processor side and drives the cfg port of the top-level MMIO responder.

Parameters:
- RESP_TIMEOUT, 16: max cycles to wait for cfg_resp_valid on any single request; 16-bit counter.
- POLL_GAP, 4: idle cycles before each status poll; 0 is legal and means no gap.
- POLL_LIMIT, 1024: max status polls per descriptor before a timeout error; 16-bit counter.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- desc_valid, input, 1: descriptor offered.
- desc_ready, output, 1: block can accept a descriptor.
- desc_src, input, 64: DMA source address.
- desc_dst, input, 64: DMA destination address.
- desc_len, input, 32: transfer length.
- busy, output, 1: a descriptor is in flight.
- done, output, 1: one-cycle completion pulse.
- done_err, output, 1: qualifies done; 1 means timeout.
- cfg_req_valid, output, 1: MMIO request valid.
- cfg_req_addr, output, 32: MMIO address.
- cfg_req_wdata, output, 32: MMIO write data.
- cfg_resp_valid, input, 1: MMIO response valid; may assert in the same cycle as the request.
- cfg_resp_rdata, input, 32: MMIO read data; bit0 = DMA done at status address.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, done_err=0.
  - cfg_req_valid=0, cfg_req_addr=0, cfg_req_wdata=0.
  - desc_ready=1, since it is decoded from state==IDLE.
- Descriptor acceptance:
  - Accept on a clock edge where desc_valid & desc_ready.
  - src, dst and len are captured into internal registers; the inputs are ignored afterwards.
  - busy=1 from the cycle after acceptance until the cycle done is high, inclusive.
- Zero length (desc_len==0):
  - No cfg traffic.
  - done=1, done_err=0 in the cycle after acceptance; then return to IDLE.
- States: IDLE -> WRITE -> GAP -> POLL -> FINISH -> IDLE.
- WRITE: six requests in order, each with cfg_req_valid=1.
  - 0x10: src[31:0]
  - 0x14: src[63:32]
  - 0x18: dst[31:0]
  - 0x1C: dst[63:32]
  - 0x20: len
  - 0x24: wdata 0x00000001
- Request handshake (applies to every request):
  - addr and wdata are registered outputs, stable while valid=1.
  - The request completes on the first edge where cfg_req_valid & cfg_resp_valid.
  - The next request is driven in the following cycle, with no bubble.
  - Against a same-cycle echo responder, each write takes exactly 1 cycle, so the WRITE phase takes 6 cycles.
  - Only one request is outstanding; cfg_resp_valid while cfg_req_valid=0 is ignored.
- Response timeout:
  - A counter resets at each new request and counts cycles while waiting.
  - Reaching RESP_TIMEOUT without a response: deassert valid, go to FINISH with error.
- GAP: hold cfg_req_valid=0 for POLL_GAP cycles, then go to POLL.
- POLL:
  - Read request: addr=0x2C, wdata=0, valid=1.
  - On the response, if cfg_resp_rdata[0]=1, go to FINISH with success.
  - Otherwise increment the poll count. If the count reaches POLL_LIMIT, go to FINISH with error; else go back to GAP.
  - rdata[31:1] are ignored.
- FINISH: done=1 for one cycle, with done_err=1 on timeout and 0 otherwise; then IDLE.
- desc_valid during busy is not accepted (desc_ready=0). Back-to-back descriptors: desc_ready=1 in the cycle after done.
- Reset mid-operation: abort immediately. cfg_req_valid drops asynchronously and no done pulse is generated. The downstream DMA is not cleaned up; that is the responder's reset responsibility.
- Counters saturate and never wrap. Poll and response counters clear on acceptance.

Test Plan:
1. Basic transfer:
   - Stimulus: src=0x0000_1234_5678_9ABC, dst=0x0000_0000_0000_4000, len=64; echo responder; status bit0=1 on the first poll.
   - Required response: writes (0x10,0x56789ABC), (0x14,0x00001234), (0x18,0x00004000), (0x1C,0), (0x20,64), (0x24,1) on consecutive cycles; a 4-cycle gap; poll 0x2C; done=1, done_err=0.
2. Slow poll:
   - Stimulus: status bit0=0 for 3 polls, then 1.
   - Required response: exactly 4 reads of 0x2C, each preceded by a 4-cycle gap; done with done_err=0.
3. Poll timeout:
   - Stimulus: POLL_LIMIT=8, status never set.
   - Required response: 8 polls, then done=1, done_err=1; desc_ready=1 in the next cycle.
4. Response timeout:
   - Stimulus: responder withholds cfg_resp_valid on write 0x18.
   - Required response: cfg_req_valid held with addr 0x18 for 16 cycles, then dropped; done=1, done_err=1; no further requests.
5. Zero length:
   - Stimulus: desc_len=0.
   - Required response: no cfg_req_valid; done=1 one cycle after acceptance.
6. Mid-transfer reset:
   - Stimulus: assert rst_n=0 during the POLL gap; release, then send a new descriptor.
   - Required response: all outputs return to reset values immediately, no done pulse; the new descriptor runs the full 6-write sequence from 0x10.
